// File: rtl/wimax_phy_seq_ctrl.sv
// Run-control sequencer for the WiMAX PHY chain.
// Lock wait, seed load, settle, frame checking, sticky verdict.
module wimax_phy_seq_ctrl #(
    parameter int SETTLE_CYCLES = 10,
    parameter int NUM_FRAMES    = 8,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int FRAME_TIMEOUT = 1024,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   clk_ref,
    input  logic                   reset_N,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   pll_locked,
    input  logic                   frame_done,
    input  logic [3:0]             stage_pass,
    output logic                   load,
    output logic                   en,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [2:0]             err_code,
    output logic [3:0]             fail_mask,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int MAX_A = (LOCK_TIMEOUT > FRAME_TIMEOUT) ?
                           LOCK_TIMEOUT : FRAME_TIMEOUT;
    localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ?
                           MAX_A : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAMES_END = FRAME_CNT_W'(NUM_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_inc;
    logic [2:0]             err_code_q, err_code_d;
    logic [3:0]             fail_mask_q, fail_mask_d;
    logic                   lock_meta_q, lock_sync_q;
    logic                   load_q, load_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fail_q, fail_d;

    // State, shared counter, verdict and synchroniser registers
    always_ff @(posedge clk_ref or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            err_code_q  <= '0;
            fail_mask_q <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_code_q  <= err_code_d;
            fail_mask_q <= fail_mask_d;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Saturating frame counter increment
    always_comb begin
        frame_inc = frame_cnt_q;
        if (frame_cnt_q != '1) begin
            frame_inc = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // Next state; one counter serves lock wait, settle and watchdog
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        frame_cnt_d = frame_cnt_q;
        err_code_d  = err_code_q;
        fail_mask_d = fail_mask_q;
        if (abort) begin
            state_d     = S_IDLE;
            err_code_d  = 3'd0;
            fail_mask_d = 4'h0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_d     = S_WAIT_LOCK;
                        err_code_d  = 3'd0;
                        fail_mask_d = 4'h0;
                        frame_cnt_d = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_sync_q) begin
                        state_d = S_LOAD;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d    = S_FAIL;
                        err_code_d = 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_sync_q) begin
                        state_d    = S_FAIL;
                        err_code_d = 3'd2;
                    end else if (frame_done) begin
                        frame_cnt_d = frame_inc;
                        if (stage_pass != 4'hF) begin
                            state_d     = S_FAIL;
                            err_code_d  = 3'd4;
                            fail_mask_d = ~stage_pass;
                        end else if (frame_inc == FRAMES_END) begin
                            state_d = S_DONE;
                        end
                    end else if (cnt_q == FRAME_LAST) begin
                        state_d    = S_FAIL;
                        err_code_d = 3'd3;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the upcoming state into registered outputs
    always_comb begin
        load_d = (state_d == S_LOAD);
        en_d   = (state_d == S_RUN);
        busy_d = (state_d == S_WAIT_LOCK) || (state_d == S_LOAD) ||
                 (state_d == S_SETTLE) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        fail_d = (state_d == S_FAIL);
    end

    // Output registers
    always_ff @(posedge clk_ref or negedge reset_N) begin
        if (!reset_N) begin
            load_q <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            load_q <= load_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
            fail_q <= fail_d;
        end
    end

    assign load      = load_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign err_code  = err_code_q;
    assign fail_mask = fail_mask_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_wimax_phy_seq_ctrl.sv
// Bench for wimax_phy_seq_ctrl.
// Directed scenarios followed by randomized runs against a verdict model.
module tb_wimax_phy_seq_ctrl;

    localparam int S  = 10;
    localparam int NF = 8;
    localparam int LT = 4096;
    localparam int FT = 1024;
    localparam int W  = 16;

    logic         clk_ref = 1'b0;
    logic         reset_N = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         pll_locked = 1'b0;
    logic         frame_done = 1'b0;
    logic [3:0]   stage_pass = 4'hF;
    logic         load, en, busy, done, fail;
    logic [2:0]   err_code;
    logic [3:0]   fail_mask;
    logic [W-1:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    always #10 clk_ref = ~clk_ref;

    wimax_phy_seq_ctrl #(
        .SETTLE_CYCLES(S),
        .NUM_FRAMES(NF),
        .LOCK_TIMEOUT(LT),
        .FRAME_TIMEOUT(FT),
        .FRAME_CNT_W(W)
    ) dut (
        .clk_ref(clk_ref),
        .reset_N(reset_N),
        .start(start),
        .abort(abort),
        .pll_locked(pll_locked),
        .frame_done(frame_done),
        .stage_pass(stage_pass),
        .load(load),
        .en(en),
        .busy(busy),
        .done(done),
        .fail(fail),
        .err_code(err_code),
        .fail_mask(fail_mask),
        .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_en();
        int n;
        n = 0;
        while (!en && n < 200) begin
            tick();
            n++;
        end
        chk("wait_en", en, 1);
    endtask

    // bad is 1-based frame index carrying bad_pass; 0 means all clean
    task automatic do_frames(input int n, input int bad,
                             input logic [3:0] bad_pass);
        for (int i = 1; i <= n; i++) begin
            ticks($urandom_range(0, 5));
            frame_done = 1'b1;
            stage_pass = (i == bad) ? bad_pass : 4'hF;
            tick();
            frame_done = 1'b0;
            stage_pass = 4'hF;
            if (i == bad) break;
        end
    endtask

    // Verdict of a run of NF frames where frame 'bad' carries 'bp'
    function automatic void model(input int bad, input logic [3:0] bp,
                                  output logic e_done, output logic e_fail,
                                  output logic [2:0] e_err,
                                  output logic [3:0] e_mask,
                                  output int e_cnt);
        if (bad >= 1 && bad <= NF && bp != 4'hF) begin
            e_done = 1'b0;
            e_fail = 1'b1;
            e_err  = 3'd4;
            e_mask = 4'hF ^ bp;
            e_cnt  = bad;
        end else begin
            e_done = 1'b1;
            e_fail = 1'b0;
            e_err  = 3'd0;
            e_mask = 4'h0;
            e_cnt  = NF;
        end
    endfunction

    initial begin
        int n;
        int saw_load;
        int bad;
        logic [3:0] bp;
        logic e_done, e_fail;
        logic [2:0] e_err;
        logic [3:0] e_mask;
        int e_cnt;

        ticks(2);
        chk("rst_load", load, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_code, 0);
        chk("rst_mask", fail_mask, 0);
        chk("rst_cnt", frame_cnt, 0);
        reset_N = 1'b1;

        // clean run
        pll_locked = 1'b1;
        ticks(4);
        launch();
        chk("t1_busy", busy, 1);
        n = 1;
        while (!load && n < 20) begin
            tick();
            n++;
        end
        chk("t1_load_lat", n, 2);
        tick();
        chk("t1_load_width", load, 0);
        n = 0;
        while (!en && n < 50) begin
            tick();
            n++;
        end
        chk("t1_settle", n, S);
        do_frames(NF, 0, 4'hF);
        chk("t1_done", done, 1);
        chk("t1_fail", fail, 0);
        chk("t1_err", err_code, 0);
        chk("t1_cnt", frame_cnt, NF);
        chk("t1_en_off", en, 0);
        chk("t1_busy_off", busy, 0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        chk("t1_ignore_fd", frame_cnt, NF);

        // lock timeout
        pll_locked = 1'b0;
        ticks(3);
        launch();
        chk("t2_done_clr", done, 0);
        chk("t2_cnt_clr", frame_cnt, 0);
        n = 0;
        saw_load = 0;
        while (!fail && n < 5000) begin
            tick();
            n++;
            if (load) saw_load = 1;
        end
        chk("t2_lat", n, LT);
        chk("t2_err", err_code, 1);
        chk("t2_no_load", saw_load, 0);
        chk("t2_busy", busy, 0);

        // stage mismatch on frame 3
        pll_locked = 1'b1;
        ticks(3);
        launch();
        chk("t3_fail_clr", fail, 0);
        wait_en();
        do_frames(NF, 3, 4'b1011);
        chk("t3_fail", fail, 1);
        chk("t3_err", err_code, 4);
        chk("t3_mask", fail_mask, 4'b0100);
        chk("t3_cnt", frame_cnt, 3);
        chk("t3_en", en, 0);
        chk("t3_done", done, 0);

        // frame watchdog
        launch();
        wait_en();
        n = 0;
        while (!fail && n < 2000) begin
            tick();
            n++;
        end
        chk("t4_lat", n, FT);
        chk("t4_err", err_code, 3);

        // lock lost in RUN, then recovery
        launch();
        wait_en();
        do_frames(2, 0, 4'hF);
        pll_locked = 1'b0;
        n = 0;
        while (!fail && n < 10) begin
            tick();
            n++;
        end
        chk("t5_lat", (n >= 1 && n <= 3), 1);
        chk("t5_err", err_code, 2);
        chk("t5_cnt", frame_cnt, 2);
        pll_locked = 1'b1;
        ticks(3);
        launch();
        chk("t5_fail_clr", fail, 0);
        chk("t5_err_clr", err_code, 0);
        chk("t5_cnt_clr", frame_cnt, 0);
        wait_en();
        do_frames(NF, 0, 4'hF);
        chk("t5_done", done, 1);
        chk("t5_cnt", frame_cnt, NF);

        // abort in SETTLE
        launch();
        ticks(3);
        chk("t6_in_settle", busy && !load && !en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_load", load, 0);
        chk("t6_en", en, 0);
        chk("t6_done", done, 0);
        ticks(S + 5);
        chk("t6_stay_idle", en, 0);

        // abort in RUN holds frame_cnt
        launch();
        wait_en();
        do_frames(3, 0, 4'hF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6a_en", en, 0);
        chk("t6a_busy", busy, 0);
        chk("t6a_cnt", frame_cnt, 3);

        // asynchronous reset in RUN
        launch();
        wait_en();
        do_frames(2, 0, 4'hF);
        #3;
        reset_N = 1'b0;
        #1;
        chk("t6r_en", en, 0);
        chk("t6r_load", load, 0);
        chk("t6r_busy", busy, 0);
        chk("t6r_cnt", frame_cnt, 0);
        tick();
        reset_N = 1'b1;
        ticks(3);

        // randomized runs; first one fails on the final frame
        for (int r = 0; r < 8; r++) begin
            bad = (r == 0) ? NF : $urandom_range(0, NF);
            bp  = 4'($urandom_range(0, 14));
            model(bad, bp, e_done, e_fail, e_err, e_mask, e_cnt);
            launch();
            wait_en();
            do_frames(NF, bad, bp);
            chk("rnd_done", done, e_done);
            chk("rnd_fail", fail, e_fail);
            chk("rnd_err", err_code, e_err);
            chk("rnd_mask", fail_mask, e_mask);
            chk("rnd_cnt", frame_cnt, e_cnt);
            ticks(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
